// File: rtl/ifu_fetchq.sv
// -----------------------------------------------------------------------------
// ifu_fetchq -- pipelined instruction fetch unit with an instruction queue.
//
// Keeps up to OUTS_DEPTH fetch requests outstanding on the instruction bus and
// buffers returned instructions, tagged with their PCs, in an IQ_DEPTH-entry
// queue that feeds EXU decode. An EXU redirect flushes the queue, discards
// every response still in flight and restarts fetch at the new PC.
//
// Optional build: define IFU_FETCHQ_PERF_EN to add the performance counters
// perf_fetch_cnt (EXU pops) and perf_kill_cnt (dropped responses).
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   pc_rtvec                   reset vector, sampled in the BOOT cycle
//   ifu_req_valid/ready/pc     fetch request channel to the bus
//   ifu_rsp_valid/ready/instr  in-order fetch response channel
//   ifu_o_valid/ready/ir/pc    queue head toward EXU decode
//   redirect_valid/pc          single-cycle flush and redirect from EXU
//   inspect_pc                 next fetch PC (debug)
//   perf_fetch_cnt/kill_cnt    saturating counters (IFU_FETCHQ_PERF_EN only)
// -----------------------------------------------------------------------------
module ifu_fetchq #(
   parameter int PC_W       = 32,
   parameter int INSTR_W    = 32,
   parameter int OUTS_DEPTH = 2,
   parameter int IQ_DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PC_W-1:0]    pc_rtvec,
   output logic               ifu_req_valid,
   input  logic               ifu_req_ready,
   output logic [PC_W-1:0]    ifu_req_pc,
   input  logic               ifu_rsp_valid,
   output logic               ifu_rsp_ready,
   input  logic [INSTR_W-1:0] ifu_rsp_instr,
   output logic               ifu_o_valid,
   input  logic               ifu_o_ready,
   output logic [INSTR_W-1:0] ifu_o_ir,
   output logic [PC_W-1:0]    ifu_o_pc,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [PC_W-1:0]    inspect_pc
`ifdef IFU_FETCHQ_PERF_EN
   ,
   output logic [31:0]        perf_fetch_cnt,
   output logic [31:0]        perf_kill_cnt
`endif
);

   // One counter width covers outstanding, kill and queue occupancy counts.
   localparam int CW = $clog2(IQ_DEPTH + OUTS_DEPTH) + 1;
   localparam int TW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
   localparam int QW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
   localparam logic [CW-1:0] OUTS_MAX = CW'(OUTS_DEPTH);
   localparam logic [CW-1:0] IQ_MAX   = CW'(IQ_DEPTH);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state;
   logic [PC_W-1:0]   fetch_pc;
   logic [CW-1:0]     outs_cnt;
   logic [CW-1:0]     kill_cnt;
   logic [CW-1:0]     kill_nxt;
   logic [CW-1:0]     iq_cnt;

   // PC tags of outstanding requests; responses return in order so a FIFO
   // pairs each instruction with the address that fetched it.
   logic [PC_W-1:0]   tag_mem [OUTS_DEPTH];
   logic [TW-1:0]     tag_wr;
   logic [TW-1:0]     tag_rd;

   logic [PC_W-1:0]   iq_pc [IQ_DEPTH];
   logic [INSTR_W-1:0] iq_ir [IQ_DEPTH];
   logic [QW-1:0]     iq_wr;
   logic [QW-1:0]     iq_rd;

   logic              redir;
   logic              req_hs;
   logic              rsp_hs;
   logic              drop;
   logic              iq_push;
   logic              iq_pop;
   logic              unused_lsb;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TW'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [QW-1:0] iq_inc(input logic [QW-1:0] p);
      return (p == QW'(IQ_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Fetch addresses are halfword aligned; bit 0 of any incoming PC is dropped.
   assign unused_lsb = pc_rtvec[0] ^ redirect_pc[0];

   // Redirect is meaningless before the reset vector has been loaded.
   assign redir = redirect_valid & (state != BOOT);

   // Credits: a request is only issued when its response is guaranteed a queue
   // slot, so the response channel can be permanently ready.
   assign ifu_req_valid = (state == RUN) & ~redirect_valid
                        & (outs_cnt < OUTS_MAX)
                        & ((outs_cnt + iq_cnt) < IQ_MAX);
   assign ifu_req_pc    = fetch_pc;
   assign ifu_rsp_ready = 1'b1;
   assign inspect_pc    = fetch_pc;

   assign req_hs  = ifu_req_valid & ifu_req_ready;
   // A response with nothing outstanding is a bus protocol error and is ignored.
   assign rsp_hs  = ifu_rsp_valid & (outs_cnt != '0);
   assign drop    = rsp_hs & (redir | (kill_cnt != '0));
   assign iq_push = rsp_hs & ~drop;
   // A pop coinciding with a redirect is swallowed by the flush.
   assign iq_pop  = ifu_o_valid & ifu_o_ready & ~redir;

   // Every response still owed by the bus at redirect time belongs to the old
   // stream; one returning in the redirect cycle is already dropped here.
   always_comb begin
      kill_nxt = kill_cnt;
      if (redir)
         kill_nxt = outs_cnt - CW'(rsp_hs);
      else if (drop)
         kill_nxt = kill_cnt - 1'b1;
   end

   assign ifu_o_valid = (iq_cnt != '0);
   assign ifu_o_ir    = ifu_o_valid ? iq_ir[iq_rd] : '0;
   assign ifu_o_pc    = ifu_o_valid ? iq_pc[iq_rd] : '0;

   // Control state, counters and pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= BOOT;
         fetch_pc <= '0;
         outs_cnt <= '0;
         kill_cnt <= '0;
         tag_wr   <= '0;
         tag_rd   <= '0;
         iq_cnt   <= '0;
         iq_wr    <= '0;
         iq_rd    <= '0;
      end else begin
         case (state)
            BOOT: begin
               fetch_pc <= {pc_rtvec[PC_W-1:1], 1'b0};
               state    <= RUN;
            end
            default: begin
               // DRAIN holds off new requests until the old stream is gone.
               state <= (kill_nxt != '0) ? DRAIN : RUN;
               if (redir)
                  fetch_pc <= {redirect_pc[PC_W-1:1], 1'b0};
               else if (req_hs)
                  fetch_pc <= fetch_pc + PC_W'(4);
            end
         endcase

         kill_cnt <= kill_nxt;
         outs_cnt <= outs_cnt + CW'(req_hs) - CW'(rsp_hs);
         if (req_hs)
            tag_wr <= tag_inc(tag_wr);
         if (rsp_hs)
            tag_rd <= tag_inc(tag_rd);

         if (redir) begin
            iq_rd  <= iq_wr;
            iq_cnt <= '0;
         end else begin
            if (iq_push)
               iq_wr <= iq_inc(iq_wr);
            if (iq_pop)
               iq_rd <= iq_inc(iq_rd);
            iq_cnt <= iq_cnt + CW'(iq_push) - CW'(iq_pop);
         end
      end
   end

   // Storage arrays carry no reset; the head outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (req_hs)
         tag_mem[tag_wr] <= fetch_pc;
      if (iq_push) begin
         iq_pc[iq_wr] <= tag_mem[tag_rd];
         iq_ir[iq_wr] <= ifu_rsp_instr;
      end
   end

`ifdef IFU_FETCHQ_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch_cnt <= '0;
         perf_kill_cnt  <= '0;
      end else begin
         if (iq_pop && (perf_fetch_cnt != '1))
            perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
         if (drop && (perf_kill_cnt != '1))
            perf_kill_cnt <= perf_kill_cnt + 1'b1;
      end
   end
`else
   // Performance counters not built.
`endif

`ifndef SYNTHESIS
   rsp_without_request: assert property (@(posedge clk) disable iff (!rst)
      !(ifu_rsp_valid && (outs_cnt == '0)));
`endif

endmodule

// File: tb/tb_ifu_fetchq.sv
module tb_ifu_fetchq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_rtvec = '0;
   logic        ifu_req_valid;
   logic        ifu_req_ready = 1'b1;
   logic [31:0] ifu_req_pc;
   logic        ifu_rsp_valid = 1'b0;
   logic        ifu_rsp_ready;
   logic [31:0] ifu_rsp_instr = '0;
   logic        ifu_o_valid;
   logic        ifu_o_ready = 1'b0;
   logic [31:0] ifu_o_ir;
   logic [31:0] ifu_o_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] inspect_pc;
`ifdef IFU_FETCHQ_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_kill_cnt;
`endif

   ifu_fetchq #(.PC_W(32), .INSTR_W(32), .OUTS_DEPTH(2), .IQ_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .pc_rtvec(pc_rtvec),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
      .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_ir(ifu_o_ir), .ifu_o_pc(ifu_o_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inspect_pc(inspect_pc)
`ifdef IFU_FETCHQ_PERF_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_kill_cnt(perf_kill_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      int          due;
   } bus_t;

   typedef struct {
      logic [31:0] rtvec;
      int          lat;
      bit          toggle;
      int          stall_mod;
      int          n;
      logic [31:0] first_pc;
      logic [31:0] last_pc;
   } vec_t;

   int          ncmp = 0;
   int          nmis = 0;
   int          cyc = 0;
   int          lat = 1;
   bit          toggle = 1'b0;
   int          stall_mod = 0;
   bit          hold_ready = 1'b0;
   bus_t        bus_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_req_pc = '0;
   int          iq_m = 0;
   bit          no_redir = 1'b1;
   int          npops = 0;
   int          req_cnt = 0;
   logic [31:0] first_pop_pc = '0;
   logic [31:0] last_pc = '0;
   bit          s_o_valid = 1'b0;
   bit          s_req_valid = 1'b0;

   function automatic logic [31:0] fi(input logic [31:0] pc);
      return pc ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      ncmp++;
      if (act !== expv) begin
         nmis++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // One bus/EXU cycle: drive inputs at negedge, sample just after.
   // mode 0: no redirect, 1: redirect, 2: redirect once a response, a valid
   // head and two outstanding requests coincide (head is popped too).
   task automatic step(input int mode, input logic [31:0] rpc, output bit did);
      bit          req_hs;
      bit          rsp_hs;
      bit          pop;
      logic [31:0] e;
      @(negedge clk);
      cyc++;
      ifu_req_ready  = toggle ? (cyc % 2 == 1) : 1'b1;
      ifu_rsp_valid  = (bus_q.size() > 0) && (bus_q[0].due <= cyc);
      ifu_rsp_instr  = ifu_rsp_valid ? fi(bus_q[0].pc) : '0;
      ifu_o_ready    = !hold_ready && (stall_mod == 0 || (cyc % stall_mod) != 0);
      redirect_valid = (mode == 1);
      redirect_pc    = rpc;
      #1;
      if (mode == 2 && ifu_rsp_valid && ifu_o_valid && bus_q.size() == 2) begin
         redirect_valid = 1'b1;
         ifu_o_ready    = 1'b1;
         #1;
      end
      did         = redirect_valid;
      s_o_valid   = ifu_o_valid;
      s_req_valid = ifu_req_valid;
      chk("rsp_ready", 32'(ifu_rsp_ready), 32'd1);
      if (no_redir)
         chk("o_valid_vs_occupancy", 32'(ifu_o_valid), 32'(iq_m != 0));
      if (redirect_valid)
         chk("req_valid_on_redirect", 32'(ifu_req_valid), 32'd0);
      req_hs = ifu_req_valid && ifu_req_ready;
      rsp_hs = ifu_rsp_valid;
      pop    = ifu_o_valid && ifu_o_ready && !redirect_valid;
      if (pop) begin
         if (exp_q.size() == 0) begin
            ncmp++;
            nmis++;
            $display("FAIL pop_unexpected: got pc %h want no entry (t=%0t)", ifu_o_pc, $time);
         end else begin
            e = exp_q.pop_front();
            chk("o_pc", ifu_o_pc, e);
            chk("o_ir", ifu_o_ir, fi(e));
         end
         if (npops == 0)
            first_pop_pc = ifu_o_pc;
         last_pc = ifu_o_pc;
         npops++;
      end
      if (rsp_hs)
         void'(bus_q.pop_front());
      if (req_hs) begin
         chk("req_pc", ifu_req_pc, exp_req_pc);
         bus_q.push_back('{pc: ifu_req_pc, due: cyc + lat});
         exp_q.push_back(exp_req_pc);
         exp_req_pc += 32'd4;
         req_cnt++;
      end
      if (no_redir)
         iq_m += int'(rsp_hs) - int'(pop);
      if (redirect_valid) begin
         exp_q.delete();
         exp_req_pc = {redirect_pc[31:1], 1'b0};
         no_redir   = 1'b0;
      end
   endtask

   task automatic do_reset(input logic [31:0] rv);
      @(negedge clk);
      rst            = 1'b0;
      pc_rtvec       = rv;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ifu_rsp_valid  = 1'b0;
      ifu_rsp_instr  = '0;
      ifu_req_ready  = 1'b1;
      ifu_o_ready    = 1'b0;
      #1;
      chk("rst_req_valid", 32'(ifu_req_valid), 32'd0);
      chk("rst_o_valid", 32'(ifu_o_valid), 32'd0);
      chk("rst_o_ir", ifu_o_ir, 32'd0);
      chk("rst_o_pc", ifu_o_pc, 32'd0);
      chk("rst_inspect_pc", inspect_pc, 32'd0);
      bus_q.delete();
      exp_q.delete();
      iq_m     = 0;
      no_redir = 1'b1;
      npops    = 0;
      req_cnt  = 0;
      @(negedge clk);
      rst        = 1'b1;
      cyc        = 0;
      exp_req_pc = {rv[31:1], 1'b0};
      #1;
      chk("boot_req_valid", 32'(ifu_req_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("boot_inspect_pc", inspect_pc, {rv[31:1], 1'b0});
   endtask

   task automatic run_pops(input int n, input int budget);
      int target;
      int k;
      bit d;
      target = npops + n;
      k = 0;
      while (npops < target && k < budget) begin
         step(0, '0, d);
         k++;
      end
      chk("pops_within_budget", 32'(npops), 32'(target));
   endtask

   vec_t tbl[4];

   initial begin
      bit d;
      int k;
      tbl[0] = '{32'h8000_0000, 1, 1'b0, 0, 8,   32'h8000_0000, 32'h8000_001C};
      tbl[1] = '{32'h8000_0000, 3, 1'b1, 0, 100, 32'h8000_0000, 32'h8000_018C};
      tbl[2] = '{32'h0000_0003, 2, 1'b0, 3, 12,  32'h0000_0002, 32'h0000_002E};
      tbl[3] = '{32'hFFFF_FFF8, 1, 1'b0, 0, 4,   32'hFFFF_FFF8, 32'h0000_0004};

      // Streaming scenarios.
      for (int i = 0; i < 4; i++) begin
         lat        = tbl[i].lat;
         toggle     = tbl[i].toggle;
         stall_mod  = tbl[i].stall_mod;
         hold_ready = 1'b0;
         do_reset(tbl[i].rtvec);
         run_pops(tbl[i].n, 3000);
         chk("vec_first_pc", first_pop_pc, tbl[i].first_pc);
         chk("vec_last_pc", last_pc, tbl[i].last_pc);
      end

      // EXU backpressure: credits cap requests at the queue depth.
      lat = 1; toggle = 1'b0; stall_mod = 0; hold_ready = 1'b1;
      do_reset(32'h8000_0000);
      repeat (20) step(0, '0, d);
      chk("bp_req_cnt", 32'(req_cnt), 32'd4);
      chk("bp_req_valid", 32'(s_req_valid), 32'd0);
      chk("bp_o_valid", 32'(s_o_valid), 32'd1);
      hold_ready = 1'b0;
      run_pops(8, 200);
      chk("bp_last_pc", last_pc, 32'h8000_001C);

      // Redirect with two requests in flight.
      lat = 4; hold_ready = 1'b0;
      do_reset(32'h8000_0000);
      k = 0;
      while (bus_q.size() < 2 && k < 10) begin
         step(0, '0, d);
         k++;
      end
      chk("redir_two_inflight", 32'(bus_q.size()), 32'd2);
      step(1, 32'h8000_1001, d);
      step(0, '0, d);
      chk("redir_queue_empty", 32'(s_o_valid), 32'd0);
      chk("redir_no_req_drain", 32'(s_req_valid), 32'd0);
      run_pops(4, 200);
      chk("redir_first_pc", first_pop_pc, 32'h8000_1000);

      // Redirect coinciding with a response handshake and an EXU pop.
      lat = 2; hold_ready = 1'b1;
      do_reset(32'h4000_0000);
      d = 1'b0;
      k = 0;
      while (!d && k < 20) begin
         step(2, 32'h4000_2000, d);
         k++;
      end
      chk("same_cycle_redirect_hit", 32'(d), 32'd1);
      step(0, '0, d);
      chk("same_cycle_queue_empty", 32'(s_o_valid), 32'd0);
      hold_ready = 1'b0;
      run_pops(5, 200);
      chk("same_cycle_first_pc", first_pop_pc, 32'h4000_2000);

      // Asynchronous reset mid-stream with three queued entries.
      lat = 1; hold_ready = 1'b1;
      do_reset(32'h8000_0000);
      k = 0;
      while (iq_m != 3 && k < 20) begin
         step(0, '0, d);
         k++;
      end
      chk("mrst_iq_three", 32'(iq_m), 32'd3);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_o_valid", 32'(ifu_o_valid), 32'd0);
      chk("mrst_req_valid", 32'(ifu_req_valid), 32'd0);
      hold_ready = 1'b0;
      do_reset(32'h0000_1235);
      run_pops(3, 100);
      chk("mrst_restart_pc", first_pop_pc, 32'h0000_1234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish by 500000");
      $fatal(1, "watchdog expired");
   end

endmodule
